// File: rtl/fu_load_store_pkg.sv
// fu_load_store_pkg: shared types and sizes for the load/store functional unit.
//   fu_op_t     : issued operation (LDUR / STUR)
//   ls_state_t  : access FSM state
//   ls_issue_t  : one issue-queue entry {op, addr, data, tag}
//   addr_misaligned() : true when an address is not 8-byte aligned
package fu_load_store_pkg;

  localparam int GPR_SIZE     = 64;
  localparam int ROB_IDX_SIZE = 4;

  typedef enum logic [0:0] {
    FU_OP_LDUR = 1'b0,
    FU_OP_STUR = 1'b1
  } fu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } ls_state_t;

  typedef struct packed {
    fu_op_t                  op;
    logic [GPR_SIZE-1:0]     addr;
    logic [GPR_SIZE-1:0]     data;
    logic [ROB_IDX_SIZE-1:0] tag;
  } ls_issue_t;

  localparam int ISSUE_W = $bits(ls_issue_t);

  function automatic logic addr_misaligned(input logic [GPR_SIZE-1:0] addr);
    return (addr[2:0] != 3'd0);
  endfunction

endpackage

// File: rtl/fu_load_store_ls_fifo.sv
// fu_load_store_ls_fifo: circular FIFO used for both the issue queue and the
// result queue. A push while full is accepted only when a pop happens on the
// same edge (the popped slot is reused).
//   in_clk, in_rst : clock, asynchronous active-high reset
//   in_push/in_data: write strobe and data
//   in_pop         : read strobe (ignored when empty)
//   out_data       : head entry
//   out_count      : number of stored entries
module fu_load_store_ls_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       in_clk,
  input  logic                       in_rst,
  input  logic                       in_push,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_pop,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] out_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             empty_s, full_s, pop_ok_s, push_ok_s;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign empty_s   = (count_r == '0);
  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign pop_ok_s  = in_pop && !empty_s;
  assign push_ok_s = in_push && (!full_s || pop_ok_s);
  assign out_data  = mem_r[rd_ptr_r];
  assign out_count = count_r;

  // Storage array and pointers.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= in_data;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      count_r <= '0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fu_load_store.sv
// fu_load_store: load/store functional unit. Issued LDUR/STUR operations are
// queued, performed one at a time over a req/ack memory port and returned in
// issue order through a result FIFO.
//   in_clk, in_rst       : clock, asynchronous active-high reset
//   in_rs_*              : issue interface (start strobe, op, addr, store data, tag)
//   out_fu_ready         : registered "may issue"
//   out_mem_* / in_mem_* : memory request/ack port
//   out_rob_* / in_rob_accept : result handshake towards the ROB
//   out_overflow         : sticky, set when a start hits a full issue queue
// Optional macro FU_LS_ALIGN_CHECK_EN: misaligned addresses fault without a
// memory request; when undefined out_rob_fault is tied to 0.
module fu_load_store
  import fu_load_store_pkg::*;
#(
  parameter int ISSUE_DEPTH  = 4,
  parameter int READY_SLACK  = 2,
  parameter int RESULT_DEPTH = 2
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_rs_start,
  input  fu_op_t                  in_rs_op,
  input  logic [GPR_SIZE-1:0]     in_rs_val_a,
  input  logic [GPR_SIZE-1:0]     in_rs_val_b,
  input  logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index,
  output logic                    out_fu_ready,
  output logic                    out_mem_req,
  output logic                    out_mem_we,
  output logic [GPR_SIZE-1:0]     out_mem_addr,
  output logic [GPR_SIZE-1:0]     out_mem_wdata,
  input  logic                    in_mem_ack,
  input  logic [GPR_SIZE-1:0]     in_mem_rdata,
  output logic                    out_rob_done,
  output logic [GPR_SIZE-1:0]     out_rob_value,
  output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
  output logic                    out_rob_fault,
  input  logic                    in_rob_accept,
  output logic                    out_overflow
);

  localparam int IQ_CW  = $clog2(ISSUE_DEPTH + 1);
  localparam int RES_CW = $clog2(RESULT_DEPTH + 1);
`ifdef FU_LS_ALIGN_CHECK_EN
  localparam int RES_W  = 1 + GPR_SIZE + ROB_IDX_SIZE;
`else
  localparam int RES_W  = GPR_SIZE + ROB_IDX_SIZE;
`endif

  ls_state_t               state_r, state_next_s;
  ls_issue_t               iq_push_s, iq_head_s;
  logic [ISSUE_W-1:0]      iq_head_bits_s;
  logic [IQ_CW-1:0]        iq_count_s, iq_count_next_s;
  logic                    iq_empty_s, iq_full_s, iq_pop_s, iq_push_ok_s;
  logic [RES_W-1:0]        res_push_data_s, res_head_s;
  logic [RES_CW-1:0]       res_count_s;
  logic                    res_empty_s, res_full_s, res_push_s, res_pop_s, res_push_ok_s;
  logic                    fu_ready_r, overflow_r, mem_req_r, req_we_r;
  logic [GPR_SIZE-1:0]     req_addr_r, req_wdata_r, res_value_r, push_value_s;
  logic [ROB_IDX_SIZE-1:0] req_tag_r, res_tag_r, push_tag_s;
  logic                    pend_r, pend_next_s, load_req_s, res_load_s;
`ifdef FU_LS_ALIGN_CHECK_EN
  logic                    res_fault_r, push_fault_s;
`endif

  assign iq_push_s = '{op: in_rs_op, addr: in_rs_val_a, data: in_rs_val_b,
                       tag: in_rs_dst_rob_index};
  assign iq_head_s = ls_issue_t'(iq_head_bits_s);

  fu_load_store_ls_fifo #(.WIDTH(ISSUE_W), .DEPTH(ISSUE_DEPTH)) u_issue_q (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_push  (in_rs_start),
    .in_data  (iq_push_s),
    .in_pop   (iq_pop_s),
    .out_data (iq_head_bits_s),
    .out_count(iq_count_s)
  );

  fu_load_store_ls_fifo #(.WIDTH(RES_W), .DEPTH(RESULT_DEPTH)) u_result_q (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_push  (res_push_s),
    .in_data  (res_push_data_s),
    .in_pop   (res_pop_s),
    .out_data (res_head_s),
    .out_count(res_count_s)
  );

  assign iq_empty_s    = (iq_count_s == '0);
  assign iq_full_s     = (iq_count_s == IQ_CW'(ISSUE_DEPTH));
  assign iq_push_ok_s  = in_rs_start && (!iq_full_s || iq_pop_s);
  assign res_empty_s   = (res_count_s == '0);
  assign res_full_s    = (res_count_s == RES_CW'(RESULT_DEPTH));
  assign res_pop_s     = !res_empty_s && in_rob_accept;
  assign res_push_ok_s = !res_full_s || res_pop_s;

`ifdef FU_LS_ALIGN_CHECK_EN
  assign res_push_data_s = {push_fault_s, push_value_s, push_tag_s};
  assign {out_rob_fault, out_rob_value, out_rob_dst_rob_index} = res_head_s;
`else
  assign res_push_data_s = {push_value_s, push_tag_s};
  assign {out_rob_value, out_rob_dst_rob_index} = res_head_s;
  assign out_rob_fault   = 1'b0;
`endif

  assign out_rob_done  = !res_empty_s;
  assign out_fu_ready  = fu_ready_r;
  assign out_overflow  = overflow_r;
  assign out_mem_req   = mem_req_r;
  assign out_mem_we    = req_we_r;
  assign out_mem_addr  = req_addr_r;
  assign out_mem_wdata = req_wdata_r;

  // Issue-queue occupancy after the coming edge, used for the ready register.
  always_comb begin
    iq_count_next_s = iq_count_s;
    if (iq_push_ok_s && !iq_pop_s) begin
      iq_count_next_s = iq_count_s + IQ_CW'(1);
    end else if (!iq_push_ok_s && iq_pop_s) begin
      iq_count_next_s = iq_count_s - IQ_CW'(1);
    end else begin
      iq_count_next_s = iq_count_s;
    end
  end

  // Access FSM next state. The ack edge pushes straight into the result FIFO
  // when it has room; otherwise the result waits in RESP (pend_r) and retries.
  always_comb begin
    state_next_s = state_r;
    iq_pop_s     = 1'b0;
    load_req_s   = 1'b0;
    res_load_s   = 1'b0;
    res_push_s   = 1'b0;
    pend_next_s  = pend_r;
    push_value_s = res_value_r;
    push_tag_s   = res_tag_r;
`ifdef FU_LS_ALIGN_CHECK_EN
    push_fault_s = res_fault_r;
`endif
    case (state_r)
      IDLE: begin
        if (!iq_empty_s) begin
          iq_pop_s   = 1'b1;
          load_req_s = 1'b1;
`ifdef FU_LS_ALIGN_CHECK_EN
          if (addr_misaligned(iq_head_s.addr)) begin
            res_load_s   = 1'b1;
            push_value_s = '0;
            push_tag_s   = iq_head_s.tag;
            push_fault_s = 1'b1;
            pend_next_s  = 1'b1;
            state_next_s = RESP;
          end else begin
            state_next_s = REQ;
          end
`else
          state_next_s = REQ;
`endif
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (in_mem_ack) begin
          res_load_s   = 1'b1;
          res_push_s   = 1'b1;
          push_value_s = req_we_r ? '0 : in_mem_rdata;
          push_tag_s   = req_tag_r;
`ifdef FU_LS_ALIGN_CHECK_EN
          push_fault_s = 1'b0;
`endif
          pend_next_s  = !res_push_ok_s;
          state_next_s = RESP;
        end else begin
          state_next_s = REQ;
        end
      end
      RESP: begin
        if (pend_r) begin
          res_push_s = 1'b1;
          if (res_push_ok_s) begin
            pend_next_s  = 1'b0;
            state_next_s = IDLE;
          end else begin
            state_next_s = RESP;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        pend_next_s  = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state, request strobe, ready and overflow flags.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_r    <= IDLE;
      mem_req_r  <= 1'b0;
      pend_r     <= 1'b0;
      fu_ready_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      mem_req_r  <= (state_next_s == REQ);
      pend_r     <= pend_next_s;
      fu_ready_r <= ((IQ_CW'(ISSUE_DEPTH) - iq_count_next_s) > IQ_CW'(READY_SLACK));
      if (in_rs_start && !iq_push_ok_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Request registers (held stable for the whole REQ phase) and captured result.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      req_we_r    <= 1'b0;
      req_addr_r  <= '0;
      req_wdata_r <= '0;
      req_tag_r   <= '0;
      res_value_r <= '0;
      res_tag_r   <= '0;
`ifdef FU_LS_ALIGN_CHECK_EN
      res_fault_r <= 1'b0;
`endif
    end else begin
      if (load_req_s) begin
        req_we_r    <= (iq_head_s.op == FU_OP_STUR);
        req_addr_r  <= iq_head_s.addr;
        req_wdata_r <= iq_head_s.data;
        req_tag_r   <= iq_head_s.tag;
      end
      if (res_load_s) begin
        res_value_r <= push_value_s;
        res_tag_r   <= push_tag_s;
`ifdef FU_LS_ALIGN_CHECK_EN
        res_fault_r <= push_fault_s;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fu_load_store.sv
// Scoreboard bench for fu_load_store: stimulus pushes expected results into a
// queue, an independent monitor pops and compares on every ROB handshake.
// Memory model returns rdata = addr + 0x11F4 after a programmable delay.
module tb_fu_load_store;
  import fu_load_store_pkg::*;

  logic                    in_clk = 1'b0;
  logic                    in_rst = 1'b1;
  logic                    in_rs_start = 1'b0;
  fu_op_t                  in_rs_op = FU_OP_LDUR;
  logic [GPR_SIZE-1:0]     in_rs_val_a = '0;
  logic [GPR_SIZE-1:0]     in_rs_val_b = '0;
  logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index = '0;
  logic                    out_fu_ready, out_mem_req, out_mem_we;
  logic [GPR_SIZE-1:0]     out_mem_addr, out_mem_wdata;
  logic                    in_mem_ack = 1'b0;
  logic [GPR_SIZE-1:0]     in_mem_rdata = '0;
  logic                    out_rob_done;
  logic [GPR_SIZE-1:0]     out_rob_value;
  logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index;
  logic                    out_rob_fault;
  logic                    in_rob_accept = 1'b0;
  logic                    out_overflow;

  fu_load_store #(.ISSUE_DEPTH(4), .READY_SLACK(2), .RESULT_DEPTH(2)) dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_rs_start(in_rs_start), .in_rs_op(in_rs_op),
    .in_rs_val_a(in_rs_val_a), .in_rs_val_b(in_rs_val_b),
    .in_rs_dst_rob_index(in_rs_dst_rob_index),
    .out_fu_ready(out_fu_ready),
    .out_mem_req(out_mem_req), .out_mem_we(out_mem_we),
    .out_mem_addr(out_mem_addr), .out_mem_wdata(out_mem_wdata),
    .in_mem_ack(in_mem_ack), .in_mem_rdata(in_mem_rdata),
    .out_rob_done(out_rob_done), .out_rob_value(out_rob_value),
    .out_rob_dst_rob_index(out_rob_dst_rob_index), .out_rob_fault(out_rob_fault),
    .in_rob_accept(in_rob_accept), .out_overflow(out_overflow)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [GPR_SIZE-1:0]     value;
    logic [ROB_IDX_SIZE-1:0] tag;
    logic                    fault;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   ack_delay = 0;
  logic mem_hold = 1'b0;
  int   wait_cnt = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_res(input logic [GPR_SIZE-1:0] v, input logic [ROB_IDX_SIZE-1:0] t,
                            input logic f);
    exp_t e;
    e.value = v; e.tag = t; e.fault = f;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge in_clk);
    #2;
  endtask

  task automatic start_op(input fu_op_t op, input logic [GPR_SIZE-1:0] a,
                          input logic [GPR_SIZE-1:0] d, input logic [ROB_IDX_SIZE-1:0] t);
    in_rs_start = 1'b1;
    in_rs_op = op;
    in_rs_val_a = a;
    in_rs_val_b = d;
    in_rs_dst_rob_index = t;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {out_fu_ready, out_mem_req, out_mem_we, out_mem_addr, out_mem_wdata,
                 out_rob_done, out_rob_value, out_rob_dst_rob_index, out_rob_fault,
                 out_overflow}, '0);
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    in_rs_start = 1'b0;
    exp_q.delete();
    #1;
    check_all_zero("reset_outputs");
    repeat (2) @(posedge in_clk);
    #2;
    in_rst = 1'b0;
    step();
    check("ready_after_reset", out_fu_ready, 1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Memory model: ack after ack_delay REQ cycles, rdata derived from the address.
  initial begin
    forever begin
      @(posedge in_clk);
      #1;
      if (out_mem_req && !mem_hold && !in_rst) begin
        if (wait_cnt == ack_delay) begin
          in_mem_ack = 1'b1;
          in_mem_rdata = out_mem_addr + 64'h11F4;
        end else begin
          in_mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        in_mem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: every accepted result is compared against the scoreboard head.
  always @(negedge in_clk) begin
    if (!in_rst && out_rob_done && in_rob_accept) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual_tag=%0h required=none", out_rob_dst_rob_index);
      end else begin
        mon_e = exp_q.pop_front();
        check("rob_value", out_rob_value, mon_e.value);
        check("rob_tag", out_rob_dst_rob_index, mon_e.tag);
        check("rob_fault", out_rob_fault, mon_e.fault);
      end
    end
  end

  logic [GPR_SIZE-1:0] t3_val [6] = '{64'h13F4, 64'h13FC, 64'h1404, 64'h140C, 64'h1414, 64'h141C};
  int   issued;
  logic saw_not_ready;
  logic saw_req;

  initial begin
    // 1: single load, same-cycle ack
    do_reset();
    in_rob_accept = 1'b1;
    ack_delay = 0;
    expect_res(64'h1234, 4'd3, 1'b0);
    start_op(FU_OP_LDUR, 64'h40, 64'h0, 4'd3);
    step();
    in_rs_start = 1'b0;
    check("t1_req_e0", out_mem_req, 1'b0);
    check("t1_done_e0", out_rob_done, 1'b0);
    step();
    check("t1_req_e1", out_mem_req, 1'b1);
    check("t1_we_e1", out_mem_we, 1'b0);
    check("t1_addr_e1", out_mem_addr, 64'h40);
    check("t1_done_e1", out_rob_done, 1'b0);
    step();
    check("t1_done_e2", out_rob_done, 1'b1);
    drain("t1_drain");

    // 2: store, ack delayed 3 cycles
    ack_delay = 3;
    expect_res(64'h0, 4'd5, 1'b0);
    start_op(FU_OP_STUR, 64'h80, 64'd77, 4'd5);
    step();
    in_rs_start = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      check("t2_req", out_mem_req, 1'b1);
      check("t2_we", out_mem_we, 1'b1);
      check("t2_wdata", out_mem_wdata, 64'd77);
      check("t2_addr", out_mem_addr, 64'h80);
      step();
    end
    check("t2_req_end", out_mem_req, 1'b0);
    check("t2_done", out_rob_done, 1'b1);
    drain("t2_drain");

    // 3: backpressure, issue only while ready
    ack_delay = 0;
    in_rob_accept = 1'b0;
    issued = 0;
    saw_not_ready = 1'b0;
    for (int c = 0; c < 60 && issued < 6; c++) begin
      if (c == 25) in_rob_accept = 1'b1;
      if (out_fu_ready) begin
        expect_res(t3_val[issued], ROB_IDX_SIZE'(8 + issued), 1'b0);
        start_op(FU_OP_LDUR, 64'h200 + 64'(8 * issued), 64'h0, ROB_IDX_SIZE'(8 + issued));
        issued++;
      end else begin
        in_rs_start = 1'b0;
        if (!in_rob_accept) saw_not_ready = 1'b1;
      end
      step();
    end
    in_rs_start = 1'b0;
    in_rob_accept = 1'b1;
    check("t3_issued", issued, 6);
    check("t3_ready_dropped", saw_not_ready, 1'b1);
    drain("t3_drain");
    check("t3_no_overflow", out_overflow, 1'b0);

    // 4: overflow while the FSM is stuck waiting for an ack
    do_reset();
    in_rob_accept = 1'b1;
    mem_hold = 1'b1;
    expect_res(64'h12F4, 4'd1, 1'b0);
    start_op(FU_OP_LDUR, 64'h100, 64'h0, 4'd1);
    step();
    in_rs_start = 1'b0;
    step();
    step();
    check("t4_busy", out_mem_req, 1'b1);
    expect_res(64'h12FC, 4'd2, 1'b0);
    start_op(FU_OP_LDUR, 64'h108, 64'h0, 4'd2);
    step();
    check("t4_ready_1free3", out_fu_ready, 1'b1);
    expect_res(64'h1304, 4'd3, 1'b0);
    start_op(FU_OP_LDUR, 64'h110, 64'h0, 4'd3);
    step();
    check("t4_ready_1free2", out_fu_ready, 1'b0);
    expect_res(64'h130C, 4'd4, 1'b0);
    start_op(FU_OP_LDUR, 64'h118, 64'h0, 4'd4);
    step();
    expect_res(64'h1314, 4'd5, 1'b0);
    start_op(FU_OP_LDUR, 64'h120, 64'h0, 4'd5);
    step();
    check("t4_overflow_before", out_overflow, 1'b0);
    start_op(FU_OP_LDUR, 64'h128, 64'h0, 4'd6);
    step();
    in_rs_start = 1'b0;
    check("t4_overflow_after", out_overflow, 1'b1);
    mem_hold = 1'b0;
    drain("t4_drain");
    check("t4_overflow_sticky", out_overflow, 1'b1);

    // 5: misaligned load
    do_reset();
    in_rob_accept = 1'b1;
    saw_req = 1'b0;
`ifdef FU_LS_ALIGN_CHECK_EN
    expect_res(64'h0, 4'd7, 1'b1);
`else
    expect_res(64'h1237, 4'd7, 1'b0);
`endif
    start_op(FU_OP_LDUR, 64'h43, 64'h0, 4'd7);
    step();
    in_rs_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (out_mem_req) saw_req = 1'b1;
      step();
    end
`ifdef FU_LS_ALIGN_CHECK_EN
    check("t5_no_mem_req", saw_req, 1'b0);
`else
    check("t5_mem_req", saw_req, 1'b1);
`endif
    drain("t5_drain");

    // 6: reset in the middle of REQ
    mem_hold = 1'b1;
    start_op(FU_OP_LDUR, 64'h300, 64'h0, 4'd9);
    step();
    in_rs_start = 1'b0;
    step();
    check("t6_req_before", out_mem_req, 1'b1);
    #1;
    in_rst = 1'b1;
    exp_q.delete();
    #1;
    check_all_zero("t6_reset_outputs");
    @(posedge in_clk);
    #2;
    in_rst = 1'b0;
    mem_hold = 1'b0;
    step();
    check("t6_ready_after", out_fu_ready, 1'b1);
    check("t6_req_after", out_mem_req, 1'b0);
    expect_res(64'h1234, 4'd3, 1'b0);
    start_op(FU_OP_LDUR, 64'h40, 64'h0, 4'd3);
    step();
    in_rs_start = 1'b0;
    drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fu_load_store.md
# fu_load_store

Load/store functional unit: the consumer end of the LS reservation station's issue interface. It accepts issued LDUR/STUR operations, performs one memory access at a time over a req/ack memory port, and returns completion results to the ROB through a small result FIFO with a handshake. The effective address is computed upstream, so `val_a` arrives as base+offset.

## Interface
Parameters:
- `ISSUE_DEPTH`, 4: issue-queue entries.
- `READY_SLACK`, 2: free entries held in reserve for starts already in flight behind the registered ready path.
- `RESULT_DEPTH`, 2: result-FIFO entries.

Ports:
- `in_clk` input 1: clock.
- `in_rst` input 1: reset, **asynchronous, active-high**.
- `in_rs_start` input 1: issue strobe.
- `in_rs_op` input `fu_op_t`: `FU_OP_LDUR` or `FU_OP_STUR`.
- `in_rs_val_a` input `GPR_SIZE`: effective address.
- `in_rs_val_b` input `GPR_SIZE`: store data.
- `in_rs_dst_rob_index` input `ROB_IDX_SIZE`: destination ROB tag.
- `out_fu_ready` output 1: registered; may issue.
- `out_mem_req` output 1: memory request.
- `out_mem_we` output 1: 1 means store.
- `out_mem_addr` output `GPR_SIZE`: memory address.
- `out_mem_wdata` output `GPR_SIZE`: store data.
- `in_mem_ack` input 1: memory acknowledge.
- `in_mem_rdata` input `GPR_SIZE`: load data; valid when `in_mem_ack` is high.
- `out_rob_done` output 1: result FIFO is non-empty.
- `out_rob_value` output `GPR_SIZE`: result value.
- `out_rob_dst_rob_index` output `ROB_IDX_SIZE`: result ROB tag.
- `out_rob_fault` output 1: access fault.
- `in_rob_accept` input 1: pops the result FIFO.
- `out_overflow` output 1: sticky error flag.

## Operation
**Issue queue.** A circular FIFO of `ISSUE_DEPTH` entries holding {op, addr, data, tag}.
- `in_rs_start` pushes an entry on the clock edge.
- A push while the queue is full is dropped and sets `out_overflow`.
- `out_fu_ready` is registered as (free entries after this edge > `READY_SLACK`).

**Access FSM.**
- **IDLE**: if the queue is non-empty, pop the head into the request registers and go to REQ.
- **REQ**:
  - Drive `out_mem_req`=1, with `we`, `addr` and `wdata` held stable from the request registers.
  - On an edge with `in_mem_ack`=1, capture the result and go to RESP.
  - The captured value is `in_mem_rdata` for a load and 0 for a store.
- **RESP**:
  - Push {value, tag, fault} into the result FIFO.
  - Go to IDLE if the push succeeds; stay in RESP while the FIFO is full.

**Result FIFO.**
- Pops when `out_rob_done` & `in_rob_accept`.
- Push and pop in the same cycle are legal, including when the FIFO is full.

**Ordering.** Results return in issue order. Stores complete only after memory acks them.

## Timing
**Reset values.**
- All outputs are 0 while `in_rst` is high, including `out_fu_ready`.
- Both queues are empty and the FSM is in IDLE.
- `out_fu_ready` rises at the first edge after reset is released.

**Latency.** From an empty unit with a same-cycle ack:
- Start sampled at edge 0.
- `out_mem_req` is high after edge 1.
- `out_rob_done` is high after edge 2.
- Each cycle of ack delay adds one cycle.

**Throughput.** One access per 3 cycles when ack arrives in the first REQ cycle.

**Issue queue boundaries.**
- Simultaneous push and pop are legal.
- When the queue is full and the FSM pops on the same edge, the push is accepted.
- Pointers wrap modulo `ISSUE_DEPTH`.

**Reset mid-access.** `out_mem_req` drops asynchronously and the request is abandoned. The memory side ignores a stale ack.

**Ack outside REQ.** Ignored.

## Configuration
`FU_LS_ALIGN_CHECK_EN`:
- **Defined**: an address with `addr[2:0]` ≠ 0 issues no memory request. The FSM goes IDLE→RESP directly and pushes value 0 with `out_rob_fault`=1.
- **Undefined**: `out_rob_fault` is tied to 0 and all addresses go to memory unchanged.

## Structure
- Shared package (`data_structures.sv`): `fu_op_t`, `GPR_SIZE`, `ROB_IDX_SIZE`, and new `ls_state_t` {IDLE, REQ, RESP}.
- Sub-module `ls_fifo` (parameterized width/depth, count output) is used for both the issue queue and the result FIFO.

## Test plan
1. **Single load.** Reset, then LDUR addr 0x40 tag 3; mem acks same cycle with rdata 0x1234. Expect `out_rob_done`=1 two edges after the start, with value 0x1234 and tag 3.
2. **Store.** STUR addr 0x80 data 77 tag 5, ack delayed 3 cycles. Expect `out_mem_we`=1, `out_mem_wdata`=77 stable through REQ, then a result with value 0 and tag 5.
3. **Backpressure.** Issue 6 loads with `in_rob_accept`=0. Expect `out_fu_ready` to drop once 2 entries are free (after the 3rd issue). Expect the result FIFO to fill to 2, no drops, and all 6 tags in order once accept rises.
4. **Overflow.** Issue 5 starts back-to-back while ack is held low. Expect the 5th dropped and `out_overflow`=1.
5. **Misalignment.** With `FU_LS_ALIGN_CHECK_EN`, LDUR addr 0x43. Expect no `out_mem_req` and a result with fault=1 and value 0.
6. **Reset mid-access.** Assert `in_rst` mid-REQ. Expect `out_mem_req` to drop in the same cycle and all outputs to be 0.
